text_buffer: RTL and testbench

- Character frame store sitting directly upstream of the ASCII/Thai glyph renderer.
- Accepts typed bytes from the UART/keyboard receiver and maintains a write cursor.
- Stores characters in a 32x4 cell grid.
- For each pixel (x, y) it supplies the 8-bit character code the renderer needs: bit 7 selects the Thai ROM, bits 6:0 give the glyph index.
- The grid covers the on-screen text window x 192..447, y 208..271, with cells 8 px wide and 16 px tall.

---
 rtl/text_buffer_pkg.sv | 57 +++++
 rtl/text_buffer_if.sv | 11 +
 rtl/text_buffer_ram.sv | 22 ++
 rtl/text_buffer.sv | 172 +++++++++++++++++
 tb/tb_text_buffer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_buffer_pkg.sv
// Shared constants, types and helpers for the text_buffer frame store.
package text_pkg;

    // Grid geometry and on-screen placement
    localparam int unsigned COLS   = 32;
    localparam int unsigned ROWS   = 4;
    localparam int unsigned X0     = 192;
    localparam int unsigned Y0     = 208;
    localparam int unsigned CELL_W = 8;
    localparam int unsigned CELL_H = 16;
    localparam int unsigned CELLS  = COLS * ROWS;
    localparam int unsigned ADDR_W = $clog2(CELLS);
    localparam int unsigned CHAR_W = 8;
    localparam int unsigned PIX_W  = 10;

    // Character codes with special meaning
    localparam logic [CHAR_W-1:0] CHAR_SPACE  = 8'h20;
    localparam logic [CHAR_W-1:0] CHAR_BS     = 8'h08;
    localparam logic [CHAR_W-1:0] CHAR_DEL    = 8'h7F;
    localparam logic [CHAR_W-1:0] CHAR_CR     = 8'h0D;
    localparam logic [CHAR_W-1:0] CHAR_CURSOR = 8'h5F;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        BYTE_PRINT,
        BYTE_BS,
        BYTE_CR,
        BYTE_IGNORE
    } byte_kind_t;

    // RAM write request
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [CHAR_W-1:0] data;
    } ram_wr_t;

    // Sort a received byte into the action it triggers
    function automatic byte_kind_t classify(input logic [CHAR_W-1:0] b);
        byte_kind_t k;
        if (b == CHAR_BS || b == CHAR_DEL) begin
            k = BYTE_BS;
        end else if (b == CHAR_CR) begin
            k = BYTE_CR;
        end else if (b >= CHAR_SPACE) begin
            k = BYTE_PRINT;
        end else begin
            k = BYTE_IGNORE;
        end
        return k;
    endfunction

endpackage

// File: rtl/text_buffer_if.sv
// Byte write handshake from the UART/keyboard receiver into text_buffer.
interface text_buffer_if;
    import text_pkg::*;

    logic              wr_valid;
    logic [CHAR_W-1:0] wr_data;
    logic              wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/text_buffer_ram.sv
// 128x8 character store: one write port, one registered read port, no reset.
// A read of the cell being written returns the previous contents.
module text_ram
    import text_pkg::*;
(
    input  logic              clk,
    input  ram_wr_t           wr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CHAR_W-1:0] rd_data
);

    logic [CHAR_W-1:0] mem [CELLS];

    // Write and read share the clock; read sees pre-write data
    always_ff @(posedge clk) begin
        if (wr.we) begin
            mem[wr.addr] <= wr.data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/text_buffer.sv
// Character frame store feeding the glyph renderer.
// Optional build macro: CURSOR_BLINK_EN adds a blinking '_' over the cursor cell.
module text_buffer
    import text_pkg::*;
`ifdef CURSOR_BLINK_EN
#(
    parameter int unsigned BLINK_CYCLES = 25_000_000
)
`endif
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    text_buffer_if.slave      wr,
    output logic              busy,
    input  logic [PIX_W-1:0]  x,
    input  logic [PIX_W-1:0]  y,
    output logic [CHAR_W-1:0] ascii_code,
    output logic [ADDR_W-1:0] cursor
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [ADDR_W-1:0] cursor_q, cursor_d;
    ram_wr_t           ram_wr;
    logic              accept;
    logic              in_win, in_win_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [CHAR_W-1:0] rd_data;

    // A pending clear always wins over an incoming byte
    assign wr.wr_ready = (state_q == IDLE) && !clear;
    assign accept      = wr.wr_valid && wr.wr_ready;
    assign cursor      = cursor_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a clear sweep ends after the last cell, clear restarts it
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR: if (!clear && clr_addr_q == LAST_ADDR) state_d = IDLE;
            IDLE:  if (clear) state_d = CLEAR;
            default: state_d = CLEAR;
        endcase
    end

    // Outputs of the FSM: RAM write request plus next clear address / cursor
    always_comb begin
        clr_addr_d = clr_addr_q;
        cursor_d   = cursor_q;
        ram_wr     = '0;
        case (state_q)
            CLEAR: begin
                ram_wr.we   = 1'b1;
                ram_wr.addr = clr_addr_q;
                ram_wr.data = CHAR_SPACE;
                clr_addr_d  = clr_addr_q + ADDR_W'(1);
                cursor_d    = '0;
            end
            IDLE: begin
                if (accept) begin
                    case (classify(wr.wr_data))
                        BYTE_PRINT: begin
                            ram_wr.we   = 1'b1;
                            ram_wr.addr = cursor_q;
                            ram_wr.data = wr.wr_data;
                            cursor_d    = cursor_q + ADDR_W'(1);
                        end
                        BYTE_BS: begin
                            if (cursor_q != '0) begin
                                ram_wr.we   = 1'b1;
                                ram_wr.addr = cursor_q - ADDR_W'(1);
                                ram_wr.data = CHAR_SPACE;
                                cursor_d    = cursor_q - ADDR_W'(1);
                            end
                        end
                        BYTE_CR: begin
                            cursor_d = ADDR_W'(((32'(cursor_q) / COLS) + 1) * COLS % CELLS);
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
        if (clear) begin
            clr_addr_d = '0;
            cursor_d   = '0;
        end
    end

    // Clear address, cursor and busy flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_addr_q <= '0;
            cursor_q   <= '0;
            busy       <= 1'b1;
        end else begin
            clr_addr_q <= clr_addr_d;
            cursor_q   <= cursor_d;
            busy       <= (state_d == CLEAR);
        end
    end

    // Pixel to cell mapping; rd_addr is don't-care outside the window
    always_comb begin
        in_win  = (x >= PIX_W'(X0)) && (x < PIX_W'(X0 + COLS * CELL_W)) &&
                  (y >= PIX_W'(Y0)) && (y < PIX_W'(Y0 + ROWS * CELL_H));
        rd_addr = ADDR_W'(((32'(y) - Y0) / CELL_H) * COLS + (32'(x) - X0) / CELL_W);
    end

    // Window flag delayed to line up with the registered RAM read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_win_q <= 1'b0;
        end else begin
            in_win_q <= in_win;
        end
    end

    text_ram u_ram (
        .clk     (clk),
        .wr      (ram_wr),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

`ifdef CURSOR_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_phase_q;
    logic               force_q;

    // Blink timebase: phase flips once per BLINK_CYCLES clocks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q   <= blink_cnt_q + BLINK_W'(1);
        end
    end

    // Cursor overlay decision, registered alongside the RAM read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            force_q <= 1'b0;
        end else begin
            force_q <= blink_phase_q && (state_q == IDLE) && (rd_addr == cursor_q);
        end
    end

    assign ascii_code = !in_win_q ? '0 : (force_q ? CHAR_CURSOR : rd_data);
`else
    assign ascii_code = in_win_q ? rd_data : '0;
`endif

endmodule

// File: tb/tb_text_buffer.sv
// Self-checking bench for text_buffer against a cell-array reference model.
module tb_text_buffer;

    logic       clk;
    logic       reset_n;
    logic       clear;
    logic [9:0] x;
    logic [9:0] y;
    logic       busy;
    logic [7:0] ascii_code;
    logic [6:0] cursor;

    text_buffer_if wr_bus ();

    text_buffer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .wr         (wr_bus),
        .busy       (busy),
        .x          (x),
        .y          (y),
        .ascii_code (ascii_code),
        .cursor     (cursor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the text grid as a flat array plus cursor and clear countdown
    logic [7:0] m_mem [128];
    int         m_cursor;
    int         m_clr_left;
    int         n_checks;
    int         n_fail;
    logic [7:0] last_ascii;

    function automatic logic [7:0] m_read(input int xv, input int yv);
        if (xv >= 192 && xv < 448 && yv >= 208 && yv < 272)
            return m_mem[((yv - 208) / 16) * 32 + (xv - 192) / 8];
        return 8'h00;
    endfunction

    task automatic m_byte(input logic [7:0] b);
        if (b == 8'h08 || b == 8'h7F) begin
            if (m_cursor > 0) begin
                m_cursor = m_cursor - 1;
                m_mem[m_cursor] = 8'h20;
            end
        end else if (b == 8'h0D) begin
            m_cursor = ((m_cursor / 32) + 1) * 32 % 128;
        end else if (b >= 8'h20) begin
            m_mem[m_cursor] = b;
            m_cursor = (m_cursor + 1) % 128;
        end
    endtask

    task automatic m_fill_spaces();
        for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
    endtask

    // One clock of stimulus; checks ready, then busy/cursor/ascii after the edge
    task automatic step(input bit v, input logic [7:0] d, input bit clr, input int xv, input int yv);
        logic [7:0] exp_ascii;
        bit         chk_ascii;
        bit         exp_ready;
        wr_bus.wr_valid = v;
        wr_bus.wr_data  = d;
        clear = clr;
        x = 10'(xv);
        y = 10'(yv);
        exp_ready = (m_clr_left == 0) && !clr;
        chk_ascii = (m_clr_left == 0);
        exp_ascii = m_read(xv, yv);
        #1;
        n_checks++;
        if (wr_bus.wr_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL wr_ready: got %b want %b (t=%0t)", wr_bus.wr_ready, exp_ready, $time);
        end
        if (clr) begin
            m_clr_left = 128;
            m_cursor = 0;
            m_fill_spaces();
        end else begin
            if (m_clr_left > 0) m_clr_left--;
            if (v && exp_ready) m_byte(d);
        end
        @(posedge clk);
        #1;
        last_ascii = ascii_code;
        n_checks++;
        if (busy !== (m_clr_left > 0)) begin
            n_fail++;
            $display("FAIL busy: got %b want %b (t=%0t)", busy, (m_clr_left > 0), $time);
        end
        n_checks++;
        if (cursor !== 7'(m_cursor)) begin
            n_fail++;
            $display("FAIL cursor: got %0d want %0d (t=%0t)", cursor, m_cursor, $time);
        end
        if (chk_ascii) begin
            n_checks++;
            if (ascii_code !== exp_ascii) begin
                n_fail++;
                $display("FAIL ascii_code x=%0d y=%0d: got %h want %h", xv, yv, ascii_code, exp_ascii);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 100, 100);
    endtask

    // Assert reset mid-cycle and check outputs drop to reset values at once
    task automatic do_reset();
        wr_bus.wr_valid = 1'b0;
        clear = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b1 || wr_bus.wr_ready !== 1'b0 || cursor !== 7'd0 || ascii_code !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b ready=%b cursor=%0d ascii=%h want 1 0 0 00",
                     busy, wr_bus.wr_ready, cursor, ascii_code);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_cursor = 0;
        m_clr_left = 128;
        m_fill_spaces();
    endtask

    task automatic test_reset();
        int busy_cnt;
        do_reset();
        busy_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            if (busy === 1'b1 && wr_bus.wr_ready === 1'b0) busy_cnt++;
            idle(1);
        end
        n_checks++;
        if (busy_cnt != 128 || busy !== 1'b0 || cursor !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_clear_len: busy cycles %0d busy=%b cursor=%0d want 128 0 0", busy_cnt, busy, cursor);
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 32; c++)
                step(1'b0, 8'h00, 1'b0, 192 + c * 8 + 3, 208 + r * 16 + 9);
    endtask

    task automatic test_writes();
        step(1'b1, 8'h41, 1'b0, 100, 100);
        step(1'b1, 8'hA1, 1'b0, 100, 100);
        step(1'b0, 8'h00, 1'b0, 192, 208);
        n_checks++;
        if (last_ascii !== 8'h41) begin n_fail++; $display("FAIL write_A: got %h want 41", last_ascii); end
        step(1'b0, 8'h00, 1'b0, 200, 208);
        n_checks++;
        if (last_ascii !== 8'hA1) begin n_fail++; $display("FAIL write_A1: got %h want a1", last_ascii); end
        n_checks++;
        if (cursor !== 7'd2) begin n_fail++; $display("FAIL write_cursor: got %0d want 2", cursor); end
        step(1'b0, 8'h00, 1'b0, 191, 208);
        n_checks++;
        if (last_ascii !== 8'h00) begin n_fail++; $display("FAIL left_edge: got %h want 00", last_ascii); end
    endtask

    task automatic test_bs_cr();
        step(1'b1, 8'h08, 1'b0, 100, 100);
        n_checks++;
        if (cursor !== 7'd1) begin n_fail++; $display("FAIL bs_cursor: got %0d want 1", cursor); end
        step(1'b0, 8'h00, 1'b0, 200, 208);
        n_checks++;
        if (last_ascii !== 8'h20) begin n_fail++; $display("FAIL bs_cell: got %h want 20", last_ascii); end
        step(1'b1, 8'h0D, 1'b0, 100, 100);
        n_checks++;
        if (cursor !== 7'd32) begin n_fail++; $display("FAIL cr_cursor: got %0d want 32", cursor); end
        step(1'b1, 8'h42, 1'b0, 100, 100);
        step(1'b0, 8'h00, 1'b0, 192, 224);
        n_checks++;
        if (last_ascii !== 8'h42) begin n_fail++; $display("FAIL cell32: got %h want 42", last_ascii); end
        repeat (3) step(1'b1, 8'h0D, 1'b0, 100, 100);
        step(1'b1, 8'h7F, 1'b0, 100, 100);
        n_checks++;
        if (cursor !== 7'd0) begin n_fail++; $display("FAIL bs_at_zero: got %0d want 0", cursor); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 128; i++) step(1'b1, 8'h5A, 1'b0, 100, 100);
        n_checks++;
        if (cursor !== 7'd0) begin n_fail++; $display("FAIL wrap_cursor: got %0d want 0", cursor); end
        step(1'b0, 8'h00, 1'b0, 447, 271);
        n_checks++;
        if (last_ascii !== 8'h5A) begin n_fail++; $display("FAIL last_cell: got %h want 5a", last_ascii); end
        step(1'b0, 8'h00, 1'b0, 448, 208);
        step(1'b0, 8'h00, 1'b0, 192, 272);
        n_checks++;
        if (last_ascii !== 8'h00) begin n_fail++; $display("FAIL bottom_edge: got %h want 00", last_ascii); end
        for (int i = 0; i < 100; i++) step(1'b1, 8'(8'h30 + i % 10), 1'b0, 100, 100);
        step(1'b1, 8'h0D, 1'b0, 100, 100);
        n_checks++;
        if (cursor !== 7'd0) begin n_fail++; $display("FAIL cr_last_row: got %0d want 0", cursor); end
        step(1'b1, 8'h0A, 1'b0, 192, 208);
        n_checks++;
        if (cursor !== 7'd0 || last_ascii !== 8'h30) begin
            n_fail++;
            $display("FAIL lf_ignored: cursor %0d cell %h want 0 30", cursor, last_ascii);
        end
    endtask

    task automatic test_clear_collision();
        int busy_cnt;
        step(1'b1, 8'h41, 1'b1, 100, 100);
        busy_cnt = 0;
        while (busy === 1'b1 && busy_cnt < 300) begin
            busy_cnt++;
            idle(1);
        end
        n_checks++;
        if (busy_cnt != 128) begin n_fail++; $display("FAIL clear_len: got %0d want 128", busy_cnt); end
        step(1'b0, 8'h00, 1'b0, 192, 208);
        n_checks++;
        if (last_ascii !== 8'h20 || cursor !== 7'd0) begin
            n_fail++;
            $display("FAIL clear_drop: cell %h cursor %0d want 20 0", last_ascii, cursor);
        end
        step(1'b0, 8'h00, 1'b1, 100, 100);
        idle(50);
        do_reset();
        idle(128);
    endtask

    task automatic test_random();
        logic [7:0] d;
        int         r;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: d = 8'h08;
                1: d = 8'h0D;
                2: d = 8'h7F;
                3: d = 8'($urandom_range(0, 31));
                default: d = 8'($urandom_range(0, 255));
            endcase
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 299) == 0,
                 $urandom_range(180, 460), $urandom_range(200, 280));
        end
        idle(130);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset_n = 1'b1;
        clear = 1'b0;
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_data = 8'h00;
        x = 10'd0;
        y = 10'd0;
        m_cursor = 0;
        m_clr_left = 128;
        last_ascii = 8'h00;
        test_reset();
        test_writes();
        test_bs_cr();
        test_wrap();
        test_clear_collision();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
